// File: rtl/exmem_arbiter.sv
// Two-requester round-robin arbiter that shares the exmem BRAM slave between the CPU Wishbone path
// (requester 0) and a second master (requester 1). Define ARB_TIMEOUT_EN for forced completion of hung slave accesses.
module exmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [7:0]          req_sel,
  input  logic [2*ADDR_W-1:0] req_adr,
  input  logic [2*DATA_W-1:0] req_wdat,
  output logic [1:0]          req_ack,
  output logic [DATA_W-1:0]   req_rdat,
  output logic                s_valid,
  output logic                s_we,
  output logic [3:0]          s_sel,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_wdat,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_rdat,
  output logic                timeout_err,
  output logic                dbg_state
);

  // Handshake: a requester holds req_valid and its fields until its one-cycle req_ack; the slave
  // sees s_valid held for the whole BUSY phase and ends it with a one-cycle s_ack.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [DATA_W-1:0] TO_RDAT = DATA_W'(32'hDEAD_BEEF);

  state_t state, state_d;
  logic   grant, grant_d;
  logic   last, last_d;
  logic   to_hit;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("exmem_arbiter: TIMEOUT_CYC must be at least 1");
  end

  assign dbg_state = state;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_d;
      grant <= grant_d;
      last  <= last_d;
    end
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    last_d   = last;
    req_ack  = 2'b00;
    req_rdat = '0;
    s_valid  = 1'b0;
    s_we     = 1'b0;
    s_sel    = 4'h0;
    s_adr    = '0;
    s_wdat   = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          // On a tie the port that did not win last time goes next.
          grant_d = (&req_valid) ? ~last : req_valid[1];
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_valid = 1'b1;
        s_we    = grant ? req_we[1]                 : req_we[0];
        s_sel   = grant ? req_sel[7:4]              : req_sel[3:0];
        s_adr   = grant ? req_adr[2*ADDR_W-1:ADDR_W] : req_adr[ADDR_W-1:0];
        s_wdat  = grant ? req_wdat[2*DATA_W-1:DATA_W] : req_wdat[DATA_W-1:0];
        if (s_ack) begin
          req_ack[grant] = 1'b1;
          req_rdat       = s_rdat;
          last_d         = grant;
          state_d        = IDLE;
        end else if (to_hit) begin
          req_ack[grant] = 1'b1;
          req_rdat       = TO_RDAT;
          last_d         = grant;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_err_q;

  // Counter reads k-1 in the k-th BUSY cycle, so the forced ack lands on BUSY cycle TIMEOUT_CYC.
  assign to_hit = (state == BUSY) && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state == BUSY) to_cnt <= to_cnt + 1'b1;
      else               to_cnt <= '0;
      if (to_hit && !s_ack) to_err_q <= 1'b1;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  a_ack_onehot: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i) !(&req_ack));

endmodule

// File: tb/tb_exmem_arbiter.sv
// Randomised scoreboard bench for exmem_arbiter: bench-owned slave, transaction-level arbitration
// model, and separate monitors for the slave request side and the requester ack side.
module tb_exmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          val[2];
  logic          we_d[2];
  logic [3:0]    sel_d[2];
  logic [AW-1:0] adr_d[2];
  logic [DW-1:0] wdat_d[2];

  logic [1:0]    req_valid, req_we, req_ack;
  logic [7:0]    req_sel;
  logic [2*AW-1:0] req_adr;
  logic [2*DW-1:0] req_wdat;
  logic [DW-1:0] req_rdat;
  logic          s_valid, s_we, s_ack, timeout_err, dbg_state;
  logic [3:0]    s_sel;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat, s_rdat;

  assign req_valid = {val[1], val[0]};
  assign req_we    = {we_d[1], we_d[0]};
  assign req_sel   = {sel_d[1], sel_d[0]};
  assign req_adr   = {adr_d[1], adr_d[0]};
  assign req_wdat  = {wdat_d[1], wdat_d[0]};

  exmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid), .req_we(req_we), .req_sel(req_sel), .req_adr(req_adr), .req_wdat(req_wdat),
    .req_ack(req_ack), .req_rdat(req_rdat),
    .s_valid(s_valid), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr), .s_wdat(s_wdat),
    .s_ack(s_ack), .s_rdat(s_rdat), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // slave behaviour knobs
  int            slave_lat_fixed = -1;
  bit            slave_mute = 1'b0;
  bit            spurious_en = 1'b0;
  bit            rdat_fixed_en = 1'b0;
  logic [DW-1:0] rdat_fixed = '0;

  // scoreboard queues: slave request {we,sel,adr,wdat}; ack {onehot,rdat}
  logic [68:0]   s_exp_q[$];
  logic [33:0]   a_exp_q[$];
  logic          gnt_log[$];
  logic [68:0]   last_s = '0;
  logic [DW-1:0] last_ack_rdat = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model (drives at posedge+1) ----------------
  initial begin
    int cnt;
    int lat;
    cnt = 0;
    lat = 0;
    s_ack = 1'b0;
    s_rdat = '0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      s_ack  = 1'b0;
      s_rdat = $urandom;
      if (!wb_rst_i && s_valid) begin
        if (cnt == 0) lat = (slave_lat_fixed >= 0) ? slave_lat_fixed : int'($urandom_range(0, 6));
        if (!slave_mute && cnt >= lat) begin
          s_ack  = 1'b1;
          s_rdat = rdat_fixed_en ? rdat_fixed : $urandom;
          cnt    = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        if (!wb_rst_i && spurious_en && $urandom_range(0, 7) == 0) s_ack = 1'b1;
      end
    end
  end

  // ---------------- reference model: one transaction at a time, round-robin on ties ----------------
  logic m_busy = 1'b0;
  logic m_last = 1'b1;
  logic m_grant = 1'b0;
  int   m_cnt = 0;

  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        m_busy = 1'b0;
        m_last = 1'b1;
        m_cnt  = 0;
        s_exp_q.delete();
        a_exp_q.delete();
      end else if (m_busy) begin
        m_cnt++;
        if (s_ack) begin
          a_exp_q.push_back({(m_grant ? 2'b10 : 2'b01), s_rdat});
          m_last = m_grant;
          m_busy = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_cnt == TO) begin
          a_exp_q.push_back({(m_grant ? 2'b10 : 2'b01), 32'hDEAD_BEEF});
          m_last = m_grant;
          m_busy = 1'b0;
        end
`endif
      end else if (val[0] || val[1]) begin
        m_grant = (val[0] && val[1]) ? !m_last : val[1];
        s_exp_q.push_back({we_d[m_grant], sel_d[m_grant], adr_d[m_grant], wdat_d[m_grant]});
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  // ---------------- monitor: slave request side ----------------
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      #1;
      if (wb_rst_i) prev = 1'b0;
      else begin
        if (s_valid && !prev) begin
          last_s = {s_we, s_sel, s_adr, s_wdat};
          if (s_exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL s_req_unexpected: got request 0x%0h, expected none", last_s);
          end else begin
            check("s_req_fields", last_s, s_exp_q.pop_front());
          end
        end
        prev = s_valid;
      end
    end
  end

  // ---------------- monitor: requester ack side ----------------
  initial begin
    logic [33:0] got;
    forever begin
      @(negedge wb_clk_i);
      #1;
      if (!wb_rst_i) begin
        if (req_ack != 2'b00) begin
          got = {req_ack, req_rdat};
          gnt_log.push_back(req_ack[1]);
          last_ack_rdat = req_rdat;
          check("ack_not_dual", {126'd0, req_ack}, {126'd0, (req_ack[1] ? 2'b10 : 2'b01)});
          if (a_exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_unexpected: got ack 0x%0h, expected none", got);
          end else begin
            check("ack_rdat", got, a_exp_q.pop_front());
          end
        end else begin
          check("rdat_zero_no_ack", req_rdat, '0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input int n, input logic we, input logic [3:0] sel, input logic [AW-1:0] adr,
                        input logic [DW-1:0] wdat, input int drop_at, output int lat);
    int start;
    bit got;
    @(posedge wb_clk_i);
    #1;
    we_d[n] = we;
    sel_d[n] = sel;
    adr_d[n] = adr;
    wdat_d[n] = wdat;
    val[n] = 1'b1;
    start = cyc;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge wb_clk_i);
      if (req_ack[n]) begin
        got = 1'b1;
        lat = cyc - start;
      end else if (i == drop_at) begin
        @(posedge wb_clk_i);
        #1;
        val[n] = 1'b0;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL req%0d_ack_wait: got no ack in 400 cycles, expected one", n);
    end
  endtask

  task automatic rel(input int n);
    @(posedge wb_clk_i);
    #1;
    val[n] = 1'b0;
  endtask

  task automatic rand_traffic(input int n, input int count);
    int lat;
    int gap;
    for (int k = 0; k < count; k++) begin
      do_req(n, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom, -1, lat);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        rel(n);
        repeat (gap - 1) @(posedge wb_clk_i);
      end
    end
    rel(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200us, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int  lat;
    int  l0;
    int  l1;
    logic exp_seq[6];
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      val[i] = 1'b0; we_d[i] = 1'b0; sel_d[i] = '0; adr_d[i] = '0; wdat_d[i] = '0;
    end
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("reset_s_valid", s_valid, 1'b0);
    check("reset_req_ack", req_ack, 2'b00);
    check("reset_timeout_err", timeout_err, 1'b0);
    check("reset_state", dbg_state, 1'b0);
    check("reset_req_rdat", req_rdat, '0);
    wb_rst_i = 1'b0;

    // both requesters held continuously: tie after reset goes to port 0, then strict alternation
    gnt_log.delete();
    fork
      begin
        repeat (3) do_req(0, 1'b0, 4'hF, $urandom, $urandom, -1, l0);
        rel(0);
      end
      begin
        repeat (3) do_req(1, 1'b1, 4'h5, $urandom, $urandom, -1, l1);
        rel(1);
      end
    join
    check("alt_count", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) check($sformatf("alt_grant%0d", i), gnt_log[i], exp_seq[i]);

    // port 0 read, slave waits 10 cycles
    slave_lat_fixed = 10;
    rdat_fixed_en = 1'b1;
    rdat_fixed = 32'h1234_5678;
    gnt_log.delete();
    do_req(0, 1'b0, 4'hF, 32'h0000_0100, '0, -1, lat);
    rel(0);
    check("read_latency", lat, 11);
    check("read_rdat", last_ack_rdat, 32'h1234_5678);
    check("read_port", (gnt_log.size() == 1) ? gnt_log[0] : 1'bx, 1'b0);
    rdat_fixed_en = 1'b0;

    // port 1 write routed to slave
    slave_lat_fixed = 2;
    gnt_log.delete();
    do_req(1, 1'b1, 4'b0011, 32'h0000_0040, 32'hAABB_CCDD, -1, lat);
    rel(1);
    check("write_fields", last_s, {1'b1, 4'b0011, 32'h0000_0040, 32'hAABB_CCDD});
    check("write_port", (gnt_log.size() == 1) ? gnt_log[0] : 1'bx, 1'b1);
    check("write_latency", lat, 3);

    // requester drops valid mid-BUSY: access still completes and is acked
    slave_lat_fixed = 5;
    do_req(0, 1'b1, 4'hC, 32'h0000_0080, 32'h0BAD_F00D, 2, lat);
    rel(0);
    check("drop_latency", lat, 6);

    // reset three cycles into BUSY
    slave_lat_fixed = 20;
    @(posedge wb_clk_i);
    #1;
    adr_d[0] = 32'h0000_0200;
    val[0] = 1'b1;
    repeat (4) @(posedge wb_clk_i);
    #3;
    wb_rst_i = 1'b1;
    #1;
    check("rst_mid_s_valid", s_valid, 1'b0);
    check("rst_mid_req_ack", req_ack, 2'b00);
    check("rst_mid_state", dbg_state, 1'b0);
    val[0] = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    slave_lat_fixed = -1;
    gnt_log.delete();
    fork
      begin do_req(0, 1'b0, 4'h1, $urandom, $urandom, -1, l0); rel(0); end
      begin do_req(1, 1'b0, 4'h2, $urandom, $urandom, -1, l1); rel(1); end
    join
    check("post_rst_tie", (gnt_log.size() == 2) ? gnt_log[0] : 1'bx, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // slave never answers: forced completion on BUSY cycle TO
    slave_mute = 1'b1;
    do_req(0, 1'b0, 4'hF, 32'h0000_0300, '0, -1, lat);
    rel(0);
    slave_mute = 1'b0;
    check("timeout_latency", lat, TO);
    check("timeout_rdat", last_ack_rdat, 32'hDEAD_BEEF);
    check("timeout_err_set", timeout_err, 1'b1);
`endif

    // random mixed traffic with spurious idle acks
    spurious_en = 1'b1;
    fork
      rand_traffic(0, 25);
      rand_traffic(1, 25);
    join
    spurious_en = 1'b0;
    repeat (5) @(posedge wb_clk_i);
    #1;
    check("s_queue_drained", s_exp_q.size(), 0);
    check("ack_queue_drained", a_exp_q.size(), 0);
`ifdef ARB_TIMEOUT_EN
    check("timeout_err_sticky", timeout_err, 1'b1);
`else
    check("timeout_err_tied", timeout_err, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
